instruction_dispatch: RTL and testbench

In-order dispatch stage between the decoder and the execution units (FX, FP, LdSt, Branch, Trap). It buffers decoded instructions in a 4-entry FIFO and tracks in-flight GPR writes in a 32-bit scoreboard. When the head instruction has no register hazard and its target unit is free, it reads the register file and drives one registered issue beat carrying the operands, unit code and decode fields that every execution unit consumes. Execution-unit writebacks clear scoreboard bits.

---
 rtl/power_isa_pkg.sv | 46 ++++
 rtl/instruction_dispatch_if.sv | 91 +++++++++
 rtl/dispatch_fifo.sv | 50 +++++
 rtl/instruction_dispatch.sv | 168 ++++++++++++++++
 tb/tb_instruction_dispatch.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/power_isa_pkg.sv
// Shared decode definitions: unit codes, format codes and the dispatch queue entry.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package power_isa_pkg;

  localparam int regWidth         = 5;
  localparam int immWidth         = 64;
  localparam int opcodeWidth      = 6;
  localparam int xOpCodeWidth     = 10;
  localparam int formatIndexRange = 5;
  localparam int unitCodeWidth    = 3;
  localparam int fifoDepth        = 4;

  localparam logic [unitCodeWidth-1:0] FXUnitCode     = 3'd0;
  localparam logic [unitCodeWidth-1:0] FPUnitCode     = 3'd1;
  localparam logic [unitCodeWidth-1:0] LdStUnitCode   = 3'd2;
  localparam logic [unitCodeWidth-1:0] BranchUnitCode = 3'd3;
  localparam logic [unitCodeWidth-1:0] TrapUnitCode   = 3'd4;

  // Instruction-format codes carried through dispatch untouched.
  typedef enum logic [formatIndexRange-1:0] {
    FORMAT_A, FORMAT_B, FORMAT_D, FORMAT_DQ, FORMAT_DS, FORMAT_DX, FORMAT_I,
    FORMAT_M, FORMAT_MD, FORMAT_MDS, FORMAT_SC, FORMAT_VA, FORMAT_VC, FORMAT_VX,
    FORMAT_X, FORMAT_XFL, FORMAT_XFX, FORMAT_XL, FORMAT_XO, FORMAT_XS,
    FORMAT_XX2, FORMAT_XX3, FORMAT_Z22, FORMAT_Z23, FORMAT_INVALID
  } format_t;

  // One decoded instruction as held in the dispatch queue.
  typedef struct packed {
    logic [unitCodeWidth-1:0]    unitCode;
    logic [opcodeWidth-1:0]      opCode;
    logic [xOpCodeWidth-1:0]     xOpCode;
    logic                        xOpCodeEnabled;
    logic [formatIndexRange-1:0] format;
    logic [regWidth-1:0]         reg1;
    logic [regWidth-1:0]         reg2;
    logic [regWidth-1:0]         reg3;
    logic [2:0]                  operandEnable;
    logic [2:0]                  operandWriteback;
    logic [immWidth-1:0]         imm;
    logic                        immEnable;
    logic                        is64Bit;
    logic [63:0]                 instructionAddress;
  } decoded_inst_t;

endpackage

// File: rtl/instruction_dispatch_if.sv
// Decoder, register-file, execution-unit and writeback signals of the dispatch stage.
// Latency: not applicable (wiring only).
// Backpressure: decodeReady_o gates decodeValid_i; unitBusy_i holds the head.
interface instruction_dispatch_if;
  import power_isa_pkg::*;

  logic                        flush_i;
  logic                        decodeValid_i;
  logic                        decodeReady_o;
  logic [unitCodeWidth-1:0]    decodeUnitCode_i;
  logic [opcodeWidth-1:0]      decodeOpCode_i;
  logic [xOpCodeWidth-1:0]     decodeXOpCode_i;
  logic                        decodeXOpCodeEnabled_i;
  logic [formatIndexRange-1:0] decodeFormat_i;
  logic [regWidth-1:0]         decodeReg1Address_i;
  logic [regWidth-1:0]         decodeReg2Address_i;
  logic [regWidth-1:0]         decodeReg3Address_i;
  logic [2:0]                  decodeOperandEnable_i;
  logic [2:0]                  decodeOperandWriteback_i;
  logic [immWidth-1:0]         decodeImm_i;
  logic                        decodeImmEnable_i;
  logic                        decodeIs64Bit_i;
  logic [63:0]                 decodeInstructionAddress_i;

  logic [regWidth-1:0]         rfReadAddress1_o;
  logic [regWidth-1:0]         rfReadAddress2_o;
  logic [regWidth-1:0]         rfReadAddress3_o;
  logic [63:0]                 rfReadData1_i;
  logic [63:0]                 rfReadData2_i;
  logic [63:0]                 rfReadData3_i;

  logic [4:0]                  unitBusy_i;

  logic                        enable_o;
  logic [unitCodeWidth-1:0]    functionalUnitCode_o;
  logic [opcodeWidth-1:0]      opCode_o;
  logic [xOpCodeWidth-1:0]     xOpCode_o;
  logic                        xOpCodeEnabled_o;
  logic [formatIndexRange-1:0] instructionFormat_o;
  logic [regWidth-1:0]         reg1Address_o;
  logic [regWidth-1:0]         reg2Address_o;
  logic [regWidth-1:0]         reg3Address_o;
  logic [63:0]                 operand1_o;
  logic [63:0]                 operand2_o;
  logic [63:0]                 operand3_o;
  logic                        operand1Enable_o;
  logic                        operand2Enable_o;
  logic                        operand3Enable_o;
  logic                        operand1Writeback_o;
  logic                        operand2Writeback_o;
  logic                        operand3Writeback_o;
  logic [immWidth-1:0]         imm_o;
  logic                        immEnable_o;
  logic                        is64Bit_o;
  logic [63:0]                 instructionAddress_o;

  logic                        wbValid_i;
  logic [regWidth-1:0]         wbAddress_i;
  logic [31:0]                 stallCount_o;

  // Dispatch stage view.
  modport master (
    input  flush_i, decodeValid_i, decodeUnitCode_i, decodeOpCode_i, decodeXOpCode_i,
           decodeXOpCodeEnabled_i, decodeFormat_i, decodeReg1Address_i, decodeReg2Address_i,
           decodeReg3Address_i, decodeOperandEnable_i, decodeOperandWriteback_i, decodeImm_i,
           decodeImmEnable_i, decodeIs64Bit_i, decodeInstructionAddress_i,
           rfReadData1_i, rfReadData2_i, rfReadData3_i, unitBusy_i, wbValid_i, wbAddress_i,
    output decodeReady_o, rfReadAddress1_o, rfReadAddress2_o, rfReadAddress3_o,
           enable_o, functionalUnitCode_o, opCode_o, xOpCode_o, xOpCodeEnabled_o,
           instructionFormat_o, reg1Address_o, reg2Address_o, reg3Address_o,
           operand1_o, operand2_o, operand3_o, operand1Enable_o, operand2Enable_o,
           operand3Enable_o, operand1Writeback_o, operand2Writeback_o, operand3Writeback_o,
           imm_o, immEnable_o, is64Bit_o, instructionAddress_o, stallCount_o
  );

  // Surrounding pipeline view (decoder, register file, execution units).
  modport slave (
    output flush_i, decodeValid_i, decodeUnitCode_i, decodeOpCode_i, decodeXOpCode_i,
           decodeXOpCodeEnabled_i, decodeFormat_i, decodeReg1Address_i, decodeReg2Address_i,
           decodeReg3Address_i, decodeOperandEnable_i, decodeOperandWriteback_i, decodeImm_i,
           decodeImmEnable_i, decodeIs64Bit_i, decodeInstructionAddress_i,
           rfReadData1_i, rfReadData2_i, rfReadData3_i, unitBusy_i, wbValid_i, wbAddress_i,
    input  decodeReady_o, rfReadAddress1_o, rfReadAddress2_o, rfReadAddress3_o,
           enable_o, functionalUnitCode_o, opCode_o, xOpCode_o, xOpCodeEnabled_o,
           instructionFormat_o, reg1Address_o, reg2Address_o, reg3Address_o,
           operand1_o, operand2_o, operand3_o, operand1Enable_o, operand2Enable_o,
           operand3Enable_o, operand1Writeback_o, operand2Writeback_o, operand3Writeback_o,
           imm_o, immEnable_o, is64Bit_o, instructionAddress_o, stallCount_o
  );

endinterface

// File: rtl/dispatch_fifo.sv
// Small synchronous FIFO with flush; head entry is visible combinationally.
// Latency: a pushed entry is at the head one cycle after the push edge.
// Backpressure: caller must not push when full nor pop when empty.
module dispatch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign head_data = mem[rd_ptr];
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);

  // Storage array: written on push only, never reset.
  always_ff @(posedge clock_i) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; flush empties in one cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/instruction_dispatch.sv
// In-order dispatch: queue decoded instructions, block on GPR hazards and busy units, issue one registered beat.
// Latency: instruction accepted at edge N issues (enable_o) after edge N+1 when hazard-free.
// Backpressure: decodeReady_o drops when the queue is full; busy unit or hazard holds the head.
module instruction_dispatch
  import power_isa_pkg::*;
(
  input logic                    clock_i,
  input logic                    reset_i,
  instruction_dispatch_if.master dif
);

  decoded_inst_t                   push_entry;
  decoded_inst_t                   head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            push;
  logic                            issue;
  logic                            hazard;
  logic                            unit_busy;
  logic [7:0]                      busy_by_code;
  logic [2:0][regWidth-1:0]        head_regs;
  logic [31:0]                     scoreboard;
  logic [31:0]                     set_mask;
  logic [31:0]                     clear_mask;

  // Pack the decoder's fields into one queue entry.
  always_comb begin
    push_entry                    = '0;
    push_entry.unitCode           = dif.decodeUnitCode_i;
    push_entry.opCode             = dif.decodeOpCode_i;
    push_entry.xOpCode            = dif.decodeXOpCode_i;
    push_entry.xOpCodeEnabled     = dif.decodeXOpCodeEnabled_i;
    push_entry.format             = dif.decodeFormat_i;
    push_entry.reg1               = dif.decodeReg1Address_i;
    push_entry.reg2               = dif.decodeReg2Address_i;
    push_entry.reg3               = dif.decodeReg3Address_i;
    push_entry.operandEnable      = dif.decodeOperandEnable_i;
    push_entry.operandWriteback   = dif.decodeOperandWriteback_i;
    push_entry.imm                = dif.decodeImm_i;
    push_entry.immEnable          = dif.decodeImmEnable_i;
    push_entry.is64Bit            = dif.decodeIs64Bit_i;
    push_entry.instructionAddress = dif.decodeInstructionAddress_i;
  end

  // Full blocks the decoder even when the head leaves this cycle (no pop-through).
  assign dif.decodeReady_o = !fifo_full && !reset_i;
  assign push              = dif.decodeValid_i && dif.decodeReady_o && !dif.flush_i;

  dispatch_fifo #(
    .WIDTH ($bits(decoded_inst_t)),
    .DEPTH (fifoDepth)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .flush     (dif.flush_i),
    .push      (push),
    .pop       (issue),
    .push_data (push_entry),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_regs            = {head.reg3, head.reg2, head.reg1};
  assign dif.rfReadAddress1_o = head.reg1;
  assign dif.rfReadAddress2_o = head.reg2;
  assign dif.rfReadAddress3_o = head.reg3;

  // Codes 5..7 map onto permanently-set busy bits so such an instruction waits for a flush.
  assign busy_by_code = {3'b111, dif.unitBusy_i};
  assign unit_busy    = busy_by_code[head.unitCode];

  // RAW/WAW check against the scoreboard as registered at the start of the cycle.
  always_comb begin
    hazard   = 1'b0;
    set_mask = '0;
    for (int n = 0; n < 3; n++) begin
      if ((head.operandEnable[n] || head.operandWriteback[n]) && scoreboard[head_regs[n]]) begin
        hazard = 1'b1;
      end
      if (head.operandWriteback[n]) begin
        set_mask[head_regs[n]] = 1'b1;
      end
    end
  end

  assign issue = !reset_i && !fifo_empty && !dif.flush_i && !unit_busy && !hazard;

  // Writeback completion clears its register bit.
  always_comb begin
    clear_mask = '0;
    if (dif.wbValid_i) begin
      clear_mask[dif.wbAddress_i] = 1'b1;
    end
  end

  // Scoreboard: clear then set, so a same-cycle set wins; flush leaves it alone.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      scoreboard <= '0;
    end else begin
      scoreboard <= (scoreboard & ~clear_mask) | (issue ? set_mask : 32'd0);
    end
  end

  // Issue beat: strobe for one cycle, payload holds between issues.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      dif.enable_o             <= 1'b0;
      dif.functionalUnitCode_o <= '0;
      dif.opCode_o             <= '0;
      dif.xOpCode_o            <= '0;
      dif.xOpCodeEnabled_o     <= 1'b0;
      dif.instructionFormat_o  <= '0;
      dif.reg1Address_o        <= '0;
      dif.reg2Address_o        <= '0;
      dif.reg3Address_o        <= '0;
      dif.operand1_o           <= '0;
      dif.operand2_o           <= '0;
      dif.operand3_o           <= '0;
      dif.operand1Enable_o     <= 1'b0;
      dif.operand2Enable_o     <= 1'b0;
      dif.operand3Enable_o     <= 1'b0;
      dif.operand1Writeback_o  <= 1'b0;
      dif.operand2Writeback_o  <= 1'b0;
      dif.operand3Writeback_o  <= 1'b0;
      dif.imm_o                <= '0;
      dif.immEnable_o          <= 1'b0;
      dif.is64Bit_o            <= 1'b0;
      dif.instructionAddress_o <= '0;
    end else begin
      dif.enable_o <= issue;
      if (issue) begin
        dif.functionalUnitCode_o <= head.unitCode;
        dif.opCode_o             <= head.opCode;
        dif.xOpCode_o            <= head.xOpCode;
        dif.xOpCodeEnabled_o     <= head.xOpCodeEnabled;
        dif.instructionFormat_o  <= head.format;
        dif.reg1Address_o        <= head.reg1;
        dif.reg2Address_o        <= head.reg2;
        dif.reg3Address_o        <= head.reg3;
        dif.operand1_o           <= dif.rfReadData1_i;
        dif.operand2_o           <= dif.rfReadData2_i;
        dif.operand3_o           <= dif.rfReadData3_i;
        dif.operand1Enable_o     <= head.operandEnable[0];
        dif.operand2Enable_o     <= head.operandEnable[1];
        dif.operand3Enable_o     <= head.operandEnable[2];
        dif.operand1Writeback_o  <= head.operandWriteback[0];
        dif.operand2Writeback_o  <= head.operandWriteback[1];
        dif.operand3Writeback_o  <= head.operandWriteback[2];
        dif.imm_o                <= head.imm;
        dif.immEnable_o          <= head.immEnable;
        dif.is64Bit_o            <= head.is64Bit;
        dif.instructionAddress_o <= head.instructionAddress;
      end
    end
  end

  // Saturating count of cycles where a valid head is held back (flush cycles excluded).
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      dif.stallCount_o <= '0;
    end else if (!fifo_empty && !dif.flush_i && !issue && (dif.stallCount_o != 32'hFFFF_FFFF)) begin
      dif.stallCount_o <= dif.stallCount_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_instruction_dispatch.sv
// Bench for instruction_dispatch: directed scenarios plus random traffic against a queue-based model.
// Latency: model predicts the registered outputs after every clock edge.
// Backpressure: model tracks occupancy to predict decodeReady_o.
module tb_instruction_dispatch;
  import power_isa_pkg::*;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;
  always #5 clock_i = ~clock_i;

  instruction_dispatch_if ifc();
  instruction_dispatch dut (.clock_i(clock_i), .reset_i(reset_i), .dif(ifc));

  logic [63:0] rf [32];
  assign ifc.rfReadData1_i = rf[ifc.rfReadAddress1_o];
  assign ifc.rfReadData2_i = rf[ifc.rfReadAddress2_o];
  assign ifc.rfReadData3_i = rf[ifc.rfReadAddress3_o];

  wire [367:0] dut_pay = {ifc.functionalUnitCode_o, ifc.opCode_o, ifc.xOpCode_o, ifc.xOpCodeEnabled_o,
    ifc.instructionFormat_o, ifc.reg1Address_o, ifc.reg2Address_o, ifc.reg3Address_o,
    ifc.operand1_o, ifc.operand2_o, ifc.operand3_o,
    ifc.operand1Enable_o, ifc.operand2Enable_o, ifc.operand3Enable_o,
    ifc.operand1Writeback_o, ifc.operand2Writeback_o, ifc.operand3Writeback_o,
    ifc.imm_o, ifc.immEnable_o, ifc.is64Bit_o, ifc.instructionAddress_o};

  // Reference model state
  decoded_inst_t mq[$];
  decoded_inst_t drv;
  logic [31:0]   m_sb;
  logic [31:0]   m_stall;
  logic          m_en;
  logic [367:0]  m_pay;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic logic [367:0] pay_of(decoded_inst_t h);
    return {h.unitCode, h.opCode, h.xOpCode, h.xOpCodeEnabled, h.format, h.reg1, h.reg2, h.reg3,
            rf[h.reg1], rf[h.reg2], rf[h.reg3],
            h.operandEnable[0], h.operandEnable[1], h.operandEnable[2],
            h.operandWriteback[0], h.operandWriteback[1], h.operandWriteback[2],
            h.imm, h.immEnable, h.is64Bit, h.instructionAddress};
  endfunction

  function automatic bit m_blocked(decoded_inst_t h);
    logic [4:0] r [3];
    r[0] = h.reg1; r[1] = h.reg2; r[2] = h.reg3;
    if (h.unitCode > 3'd4) return 1'b1;
    if (ifc.unitBusy_i[h.unitCode]) return 1'b1;
    for (int n = 0; n < 3; n++)
      if ((h.operandEnable[n] || h.operandWriteback[n]) && m_sb[r[n]]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic decoded_inst_t mk(input logic [2:0] unit, input logic [4:0] r1, input logic [4:0] r2,
                                       input logic [2:0] en, input logic [2:0] wb);
    decoded_inst_t d;
    d = '0;
    d.unitCode = unit; d.reg1 = r1; d.reg2 = r2; d.reg3 = 5'd0;
    d.operandEnable = en; d.operandWriteback = wb;
    d.opCode = 6'($urandom); d.imm = {$urandom, $urandom}; d.instructionAddress = {$urandom, $urandom};
    return d;
  endfunction

  function automatic decoded_inst_t rand_inst();
    decoded_inst_t d;
    d = mk(($urandom_range(0, 39) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom), 3'($urandom));
    d.reg3 = 5'($urandom_range(0, 7));
    d.xOpCode = 10'($urandom); d.xOpCodeEnabled = 1'($urandom); d.format = 5'($urandom);
    d.immEnable = 1'($urandom); d.is64Bit = 1'($urandom);
    return d;
  endfunction

  task automatic drive_inst(input decoded_inst_t d);
    drv = d;
    ifc.decodeUnitCode_i = d.unitCode;           ifc.decodeOpCode_i = d.opCode;
    ifc.decodeXOpCode_i = d.xOpCode;             ifc.decodeXOpCodeEnabled_i = d.xOpCodeEnabled;
    ifc.decodeFormat_i = d.format;               ifc.decodeReg1Address_i = d.reg1;
    ifc.decodeReg2Address_i = d.reg2;            ifc.decodeReg3Address_i = d.reg3;
    ifc.decodeOperandEnable_i = d.operandEnable; ifc.decodeOperandWriteback_i = d.operandWriteback;
    ifc.decodeImm_i = d.imm;                     ifc.decodeImmEnable_i = d.immEnable;
    ifc.decodeIs64Bit_i = d.is64Bit;             ifc.decodeInstructionAddress_i = d.instructionAddress;
  endtask

  // Advance one clock: model computes this edge's effect from the current inputs, then DUT clocks.
  task automatic step();
    decoded_inst_t h;
    logic [4:0] r [3];
    bit had, iss, acc;
    if (reset_i) begin
      mq.delete(); m_sb = '0; m_stall = '0; m_en = 1'b0; m_pay = '0;
    end else begin
      had = (mq.size() != 0);
      iss = 1'b0;
      acc = ifc.decodeValid_i && (mq.size() < fifoDepth) && !ifc.flush_i;
      if (had && !ifc.flush_i) begin
        h = mq[0];
        iss = !m_blocked(h);
      end
      if (had && !ifc.flush_i && !iss && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (ifc.wbValid_i) m_sb[ifc.wbAddress_i] = 1'b0;
      if (iss) begin
        r[0] = h.reg1; r[1] = h.reg2; r[2] = h.reg3;
        for (int n = 0; n < 3; n++) if (h.operandWriteback[n]) m_sb[r[n]] = 1'b1;
        m_pay = pay_of(h);
        void'(mq.pop_front());
      end
      if (ifc.flush_i) mq.delete();
      else if (acc) mq.push_back(drv);
      m_en = iss;
    end
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.decodeValid_i = 1'b0; ifc.flush_i = 1'b0; ifc.wbValid_i = 1'b0;
    ifc.wbAddress_i = '0; ifc.unitBusy_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step(); step();
    n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL reset_enable: got %b want 0", ifc.enable_o); else n_pass++;
    n_checks++; if (dut_pay !== '0) $display("FAIL reset_payload: got %h want 0", dut_pay); else n_pass++;
    n_checks++; if (ifc.stallCount_o !== 32'd0) $display("FAIL reset_stall: got %0d want 0", ifc.stallCount_o); else n_pass++;
    n_checks++; if (ifc.decodeReady_o !== 1'b0) $display("FAIL reset_ready_in_reset: got %b want 0", ifc.decodeReady_o); else n_pass++;
    n_checks++; if (dut.scoreboard !== 32'd0) $display("FAIL reset_scoreboard: got %h want 0", dut.scoreboard); else n_pass++;
    reset_i = 1'b0;
    #1;
    n_checks++; if (ifc.decodeReady_o !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", ifc.decodeReady_o); else n_pass++;
    step();
  endtask

  task automatic test_addi_and_hazard();
    decoded_inst_t d;
    logic [31:0] s0;
    rf[4] = 64'd10;
    d = mk(FXUnitCode, 5'd3, 5'd4, 3'b010, 3'b001);
    d.imm = 64'd5; d.immEnable = 1'b1; d.opCode = 6'd14;
    drive_inst(d); ifc.decodeValid_i = 1'b1;
    step();
    ifc.decodeValid_i = 1'b0;
    n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL addi_early: enable_o=%b want 0", ifc.enable_o); else n_pass++;
    step();
    n_checks++; if (ifc.enable_o !== 1'b1) $display("FAIL addi_issue: enable_o=%b want 1", ifc.enable_o); else n_pass++;
    n_checks++; if (ifc.operand2_o !== 64'd10) $display("FAIL addi_operand2: got %0d want 10", ifc.operand2_o); else n_pass++;
    n_checks++; if (ifc.imm_o !== 64'd5) $display("FAIL addi_imm: got %0d want 5", ifc.imm_o); else n_pass++;
    n_checks++; if (dut.scoreboard[3] !== 1'b1) $display("FAIL addi_sb3: got %b want 1", dut.scoreboard[3]); else n_pass++;
    n_checks++; if (dut_pay !== m_pay) $display("FAIL addi_payload: got %h want %h", dut_pay, m_pay); else n_pass++;
    // Dependent reader of r3 must wait for the writeback.
    drive_inst(mk(FXUnitCode, 5'd6, 5'd3, 3'b010, 3'b000)); ifc.decodeValid_i = 1'b1;
    step();
    ifc.decodeValid_i = 1'b0;
    s0 = m_stall;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL raw_stall_enable: got %b want 0", ifc.enable_o); else n_pass++;
    end
    n_checks++; if (ifc.stallCount_o !== s0 + 32'd3) $display("FAIL raw_stall_count: got %0d want %0d", ifc.stallCount_o, s0 + 32'd3); else n_pass++;
    ifc.wbValid_i = 1'b1; ifc.wbAddress_i = 5'd3;
    step();
    ifc.wbValid_i = 1'b0;
    n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL wb_no_bypass: enable_o=%b want 0", ifc.enable_o); else n_pass++;
    n_checks++; if (dut.scoreboard[3] !== 1'b0) $display("FAIL wb_clear: sb3=%b want 0", dut.scoreboard[3]); else n_pass++;
    step();
    n_checks++; if (ifc.enable_o !== 1'b1) $display("FAIL wb_then_issue: enable_o=%b want 1", ifc.enable_o); else n_pass++;
    n_checks++; if (ifc.operand2_o !== rf[3]) $display("FAIL dep_operand2: got %h want %h", ifc.operand2_o, rf[3]); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    ifc.unitBusy_i = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      drive_inst(mk(FXUnitCode, 5'(10 + i), 5'(20 + i), 3'b000, 3'b000));
      ifc.decodeValid_i = 1'b1;
      n_checks++; if (ifc.decodeReady_o !== (i < 4)) $display("FAIL full_ready_%0d: got %b want %b", i, ifc.decodeReady_o, (i < 4)); else n_pass++;
      step();
    end
    ifc.decodeValid_i = 1'b0;
    ifc.unitBusy_i = 5'b00000;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (ifc.enable_o !== 1'b1) $display("FAIL drain_issue_%0d: got %b want 1", i, ifc.enable_o); else n_pass++;
      n_checks++; if (ifc.reg1Address_o !== 5'(10 + i)) $display("FAIL drain_order_%0d: got %0d want %0d", i, ifc.reg1Address_o, 10 + i); else n_pass++;
    end
    step();
    n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL drain_fifth: got %b want 0", ifc.enable_o); else n_pass++;
  endtask

  task automatic test_flush();
    logic [31:0] s0;
    drive_inst(mk(FXUnitCode, 5'd7, 5'd0, 3'b000, 3'b001)); ifc.decodeValid_i = 1'b1;
    step();
    ifc.decodeValid_i = 1'b0;
    step();
    ifc.unitBusy_i = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      drive_inst(mk(FXUnitCode, 5'(12 + i), 5'd0, 3'b000, 3'b000)); ifc.decodeValid_i = 1'b1;
      step();
    end
    ifc.flush_i = 1'b1;
    step();
    ifc.flush_i = 1'b0; ifc.decodeValid_i = 1'b0; ifc.unitBusy_i = 5'b00000;
    n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL flush_enable: got %b want 0", ifc.enable_o); else n_pass++;
    s0 = m_stall;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL flush_empty_%0d: enable_o=%b want 0", i, ifc.enable_o); else n_pass++;
    end
    n_checks++; if (ifc.stallCount_o !== s0) $display("FAIL flush_stall_hold: got %0d want %0d", ifc.stallCount_o, s0); else n_pass++;
    n_checks++; if (dut.scoreboard[7] !== 1'b1) $display("FAIL flush_sb_kept: got %b want 1", dut.scoreboard[7]); else n_pass++;
    ifc.wbValid_i = 1'b1; ifc.wbAddress_i = 5'd7;
    step();
    ifc.wbValid_i = 1'b0;
    n_checks++; if (dut.scoreboard[7] !== 1'b0) $display("FAIL flush_sb_cleared: got %b want 0", dut.scoreboard[7]); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    drive_inst(mk(FXUnitCode, 5'd9, 5'd0, 3'b000, 3'b001)); ifc.decodeValid_i = 1'b1;
    step();
    ifc.unitBusy_i = 5'b00001;
    drive_inst(mk(FXUnitCode, 5'd1, 5'd2, 3'b011, 3'b000));
    step(); step();
    ifc.decodeValid_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    n_checks++; if (ifc.enable_o !== 1'b0 || dut_pay !== '0) $display("FAIL rst_mid_outputs: enable %b payload %h want 0", ifc.enable_o, dut_pay); else n_pass++;
    n_checks++; if (ifc.stallCount_o !== 32'd0) $display("FAIL rst_mid_stall: got %0d want 0", ifc.stallCount_o); else n_pass++;
    n_checks++; if (dut.scoreboard !== 32'd0) $display("FAIL rst_mid_sb: got %h want 0", dut.scoreboard); else n_pass++;
    reset_i = 1'b0; ifc.unitBusy_i = 5'b00000;
    #1;
    n_checks++; if (ifc.decodeReady_o !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", ifc.decodeReady_o); else n_pass++;
    step(); step();
    n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL rst_mid_drained: enable_o=%b want 0", ifc.enable_o); else n_pass++;
  endtask

  task automatic test_bad_unit();
    logic [31:0] s0;
    drive_inst(mk(3'd6, 5'd1, 5'd2, 3'b000, 3'b000)); ifc.decodeValid_i = 1'b1;
    step();
    ifc.decodeValid_i = 1'b0;
    s0 = m_stall;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (ifc.enable_o !== 1'b0) $display("FAIL bad_unit_issue_%0d: got %b want 0", i, ifc.enable_o); else n_pass++;
    end
    n_checks++; if (ifc.stallCount_o !== s0 + 32'd5) $display("FAIL bad_unit_stall: got %0d want %0d", ifc.stallCount_o, s0 + 32'd5); else n_pass++;
    ifc.flush_i = 1'b1;
    step();
    ifc.flush_i = 1'b0;
    step(); step();
    n_checks++; if (ifc.stallCount_o !== s0 + 32'd5) $display("FAIL bad_unit_flushed: got %0d want %0d", ifc.stallCount_o, s0 + 32'd5); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      ifc.decodeValid_i = ($urandom_range(0, 3) != 0);
      drive_inst(rand_inst());
      ifc.unitBusy_i = 5'($urandom) & 5'($urandom);
      ifc.flush_i = ($urandom_range(0, 24) == 0);
      ifc.wbValid_i = 1'($urandom);
      ifc.wbAddress_i = 5'($urandom_range(0, 7));
      step();
      n_checks++; if (ifc.enable_o !== m_en) $display("FAIL rnd_enable c%0d: got %b want %b", c, ifc.enable_o, m_en); else n_pass++;
      n_checks++; if (dut_pay !== m_pay) $display("FAIL rnd_payload c%0d: got %h want %h", c, dut_pay, m_pay); else n_pass++;
      n_checks++; if (ifc.stallCount_o !== m_stall) $display("FAIL rnd_stall c%0d: got %0d want %0d", c, ifc.stallCount_o, m_stall); else n_pass++;
      n_checks++; if (dut.scoreboard !== m_sb) $display("FAIL rnd_scoreboard c%0d: got %h want %h", c, dut.scoreboard, m_sb); else n_pass++;
      n_checks++; if (ifc.decodeReady_o !== (mq.size() < fifoDepth)) $display("FAIL rnd_ready c%0d: got %b want %b", c, ifc.decodeReady_o, (mq.size() < fifoDepth)); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    idle_inputs();
    drive_inst('0);
    test_reset();
    test_addi_and_hazard();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_bad_unit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
